// File: rtl/nasti_read_burst_splitter.sv
// Splits a NASTI INCR/FIXED read burst into sub-bursts of at most MAX_BEATS beats.
// R beats pass straight through; only the final beat of the original burst carries last.
module nasti_read_burst_splitter #(
   parameter int unsigned ID_WIDTH   = 2,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned USER_WIDTH = 1,
   parameter int unsigned MAX_BEATS  = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [ID_WIDTH-1:0]   master_ar_id_i,
   input  logic [ADDR_WIDTH-1:0] master_ar_addr_i,
   input  logic [7:0]            master_ar_len_i,
   input  logic [2:0]            master_ar_size_i,
   input  logic [1:0]            master_ar_burst_i,
   input  logic                  master_ar_lock_i,
   input  logic [3:0]            master_ar_cache_i,
   input  logic [2:0]            master_ar_prot_i,
   input  logic [3:0]            master_ar_qos_i,
   input  logic [3:0]            master_ar_region_i,
   input  logic [USER_WIDTH-1:0] master_ar_user_i,
   input  logic                  master_ar_valid_i,
   output logic                  master_ar_ready_o,
   output logic [ID_WIDTH-1:0]   master_r_id_o,
   output logic [DATA_WIDTH-1:0] master_r_data_o,
   output logic [1:0]            master_r_resp_o,
   output logic [USER_WIDTH-1:0] master_r_user_o,
   output logic                  master_r_last_o,
   output logic                  master_r_valid_o,
   input  logic                  master_r_ready_i,
   output logic [ID_WIDTH-1:0]   slave_ar_id_o,
   output logic [ADDR_WIDTH-1:0] slave_ar_addr_o,
   output logic [7:0]            slave_ar_len_o,
   output logic [2:0]            slave_ar_size_o,
   output logic [1:0]            slave_ar_burst_o,
   output logic                  slave_ar_lock_o,
   output logic [3:0]            slave_ar_cache_o,
   output logic [2:0]            slave_ar_prot_o,
   output logic [3:0]            slave_ar_qos_o,
   output logic [3:0]            slave_ar_region_o,
   output logic [USER_WIDTH-1:0] slave_ar_user_o,
   output logic                  slave_ar_valid_o,
   input  logic                  slave_ar_ready_i,
   input  logic [ID_WIDTH-1:0]   slave_r_id_i,
   input  logic [DATA_WIDTH-1:0] slave_r_data_i,
   input  logic [1:0]            slave_r_resp_i,
   input  logic                  slave_r_last_i,
   input  logic [USER_WIDTH-1:0] slave_r_user_i,
   input  logic                  slave_r_valid_i,
   output logic                  slave_r_ready_o
);

   typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

   localparam logic [1:0] BurstIncr = 2'b01;
   localparam logic [1:0] BurstWrap = 2'b10;
   localparam logic [8:0] MaxBeats  = 9'(MAX_BEATS);

   state_e                  state_q;
   logic [ID_WIDTH-1:0]     id_q;
   logic [2:0]              size_q;
   logic [1:0]              burst_q;
   logic                    lock_q;
   logic [3:0]              cache_q;
   logic [2:0]              prot_q;
   logic [3:0]              qos_q;
   logic [3:0]              region_q;
   logic [USER_WIDTH-1:0]   user_q;
   logic [8:0]              beats_left_q;
   logic [8:0]              sub_beats_q;
   logic [8:0]              r_cnt_q;
   logic [ADDR_WIDTH-1:0]   cur_addr_q;
   logic                    ar_ready_q;
   logic                    ar_valid_q;

   logic [8:0]              sub_beats;
   logic                    in_r;
   logic                    r_hs;

   // WRAP bursts are never split, whatever their length.
   always_comb begin
      sub_beats = beats_left_q;
      if (burst_q != BurstWrap && beats_left_q > MaxBeats) sub_beats = MaxBeats;
   end

   assign in_r = (state_q == StR);
   assign r_hs = in_r && slave_r_valid_i && master_r_ready_i;

   assign master_ar_ready_o = ar_ready_q;
   assign slave_ar_valid_o  = ar_valid_q;
   assign slave_ar_id_o     = id_q;
   assign slave_ar_addr_o   = cur_addr_q;
   assign slave_ar_len_o    = 8'(sub_beats - 9'd1);
   assign slave_ar_size_o   = size_q;
   assign slave_ar_burst_o  = burst_q;
   assign slave_ar_lock_o   = lock_q;
   assign slave_ar_cache_o  = cache_q;
   assign slave_ar_prot_o   = prot_q;
   assign slave_ar_qos_o    = qos_q;
   assign slave_ar_region_o = region_q;
   assign slave_ar_user_o   = user_q;

   assign master_r_valid_o = in_r && slave_r_valid_i;
   assign slave_r_ready_o  = in_r && master_r_ready_i;
   assign master_r_id_o    = slave_r_id_i;
   assign master_r_data_o  = slave_r_data_i;
   assign master_r_resp_o  = slave_r_resp_i;
   assign master_r_user_o  = slave_r_user_i;
   assign master_r_last_o  = in_r && slave_r_last_i && (beats_left_q == sub_beats_q);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= StIdle;
         id_q         <= '0;
         size_q       <= '0;
         burst_q      <= '0;
         lock_q       <= 1'b0;
         cache_q      <= '0;
         prot_q       <= '0;
         qos_q        <= '0;
         region_q     <= '0;
         user_q       <= '0;
         beats_left_q <= '0;
         sub_beats_q  <= '0;
         r_cnt_q      <= '0;
         cur_addr_q   <= '0;
         ar_ready_q   <= 1'b1;
         ar_valid_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (master_ar_valid_i) begin
                  id_q         <= master_ar_id_i;
                  size_q       <= master_ar_size_i;
                  burst_q      <= master_ar_burst_i;
                  lock_q       <= master_ar_lock_i;
                  cache_q      <= master_ar_cache_i;
                  prot_q       <= master_ar_prot_i;
                  qos_q        <= master_ar_qos_i;
                  region_q     <= master_ar_region_i;
                  user_q       <= master_ar_user_i;
                  beats_left_q <= {1'b0, master_ar_len_i} + 9'd1;
                  cur_addr_q   <= master_ar_addr_i;
                  ar_ready_q   <= 1'b0;
                  ar_valid_q   <= 1'b1;
                  state_q      <= StAr;
               end
            end
            StAr: begin
               if (slave_ar_ready_i) begin
                  sub_beats_q <= sub_beats;
                  r_cnt_q     <= '0;
                  ar_valid_q  <= 1'b0;
                  state_q     <= StR;
               end
            end
            StR: begin
               if (r_hs) begin
                  r_cnt_q <= r_cnt_q + 9'd1;
                  if (slave_r_last_i) begin
                     beats_left_q <= beats_left_q - sub_beats_q;
                     if (burst_q == BurstIncr) begin
                        cur_addr_q <= cur_addr_q + (ADDR_WIDTH'(sub_beats_q) << size_q);
                     end
                     if (beats_left_q == sub_beats_q) begin
                        ar_ready_q <= 1'b1;
                        state_q    <= StIdle;
                     end else begin
                        ar_valid_q <= 1'b1;
                        state_q    <= StAr;
                     end
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   r_last_a: assert property (@(posedge clk) disable iff (!rstn)
      r_hs |-> (slave_r_last_i == (r_cnt_q == sub_beats_q - 9'd1)))
      else $fatal(1, "slave_r_last does not match sub-burst beat count");

   r_id_a: assert property (@(posedge clk) disable iff (!rstn)
      r_hs |-> (slave_r_id_i == id_q))
      else $fatal(1, "slave_r_id does not match request id");

endmodule
